// File: rtl/spi_mem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port synchronous-read memory
// between the SPI slave path (A, lockable) and a host/debug path (B).
module spi_mem_arbiter #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          a_lock,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    conflict_cnt
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic last_gnt_b;  // 1: B was granted most recently
  logic a_elig_c;
  logic b_elig_c;
  logic a_win_c;
  logic b_win_c;
  logic conflict_c;

  // Read data is shared; the rvalid strobes identify the owner
  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;

  // Eligibility, round-robin pick and conflict detection
  always_comb begin
    a_elig_c   = 1'b0;
    b_elig_c   = 1'b0;
    a_win_c    = 1'b0;
    b_win_c    = 1'b0;
    conflict_c = 1'b0;
    a_elig_c   = a_req && !a_gnt;
    b_elig_c   = b_req && !b_gnt && !a_lock;
    a_win_c    = a_elig_c && (!b_elig_c || last_gnt_b);
    b_win_c    = b_elig_c && !a_win_c;
    // The loser counts unless it sat out only because of its own grant
    conflict_c = a_req && b_req && ((a_win_c && !b_gnt) || (b_win_c && !a_gnt));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      conflict_cnt <= '0;
      last_gnt_b   <= 1'b1;
    end else begin
      a_gnt    <= a_win_c;
      b_gnt    <= b_win_c;
      // mem_we during the grant cycle tells whether the access was a write
      a_rvalid <= a_gnt && !mem_we;
      b_rvalid <= b_gnt && !mem_we;
      if (a_win_c) begin
        mem_addr   <= a_addr;
        mem_wdata  <= a_wdata;
        mem_we     <= a_we;
        last_gnt_b <= 1'b0;
      end else if (b_win_c) begin
        mem_addr   <= b_addr;
        mem_wdata  <= b_wdata;
        mem_we     <= b_we;
        last_gnt_b <= 1'b1;
      end else begin
        mem_we <= 1'b0;
      end
      if (conflict_c && conflict_cnt != CNT_MAX)
        conflict_cnt <= conflict_cnt + CW'(1);
    end
  end

endmodule
